// File: rtl/stopwatch.sv
// Four-digit BCD stopwatch (M:SS.T) with start/stop levels, up/down counting and a tick prescaler.
// Define STOPWATCH_SATURATE_EN to hold at 9:59.9 / 0:00.0 instead of wrapping.
`timescale 1ns/1ps
module stopwatch #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Countdown,
  output logic [3:0] Tenths_Seconds,
  output logic [3:0] Ones_Seconds,
  output logic [3:0] Tens_Seconds,
  output logic [3:0] Minutes,
  output logic       run_state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          hold;
  logic [3:0]    tenths_q, ones_q, tens_q, minutes_q;
  logic [3:0]    tenths_d, ones_d, tens_d, minutes_d;

  // Stop wins over Start when both are sampled high.
  always_comb begin
    state_d = state_q;
    if (Stop)
      state_d = ST_STOPPED;
    else if (Start)
      state_d = ST_RUNNING;
  end

  // Counting uses the registered run state, giving one cycle of start/stop latency.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (state_q == ST_RUNNING) begin
      if (pre_q == PRE_MAX) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_comb begin
    hold = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
    if (Countdown)
      hold = (minutes_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0) && (tenths_q == 4'd0);
    else
      hold = (minutes_q == 4'd9) && (tens_q == 4'd5) && (ones_q == 4'd9) && (tenths_q == 4'd9);
`endif
  end

  // All four digits are computed together so they change on the same tick edge.
  always_comb begin
    tenths_d  = tenths_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    minutes_d = minutes_q;
    if (tick && !hold) begin
      if (!Countdown) begin
        if (tenths_q == 4'd9) begin
          tenths_d = 4'd0;
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            if (tens_q == 4'd5) begin
              tens_d    = 4'd0;
              minutes_d = (minutes_q == 4'd9) ? 4'd0 : minutes_q + 4'd1;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          tenths_d = tenths_q + 4'd1;
        end
      end else begin
        if (tenths_q == 4'd0) begin
          tenths_d = 4'd9;
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            if (tens_q == 4'd0) begin
              tens_d    = 4'd5;
              minutes_d = (minutes_q == 4'd0) ? 4'd9 : minutes_q - 4'd1;
            end else begin
              tens_d = tens_q - 4'd1;
            end
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end else begin
          tenths_d = tenths_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOPPED;
      pre_q     <= '0;
      tenths_q  <= 4'd0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      minutes_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      tenths_q  <= tenths_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      minutes_q <= minutes_d;
    end
  end

  assign Tenths_Seconds = tenths_q;
  assign Ones_Seconds   = ones_q;
  assign Tens_Seconds   = tens_q;
  assign Minutes        = minutes_q;
  assign run_state      = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_stopwatch.sv
// Directed, table-driven bench for the stopwatch (TICK_DIV = 1); expectations follow STOPWATCH_SATURATE_EN.
`timescale 1ns/1ps
module tb_stopwatch;

  logic       clk;
  logic       reset;
  logic       Start;
  logic       Stop;
  logic       Countdown;
  logic [3:0] Tenths_Seconds;
  logic [3:0] Ones_Seconds;
  logic [3:0] Tens_Seconds;
  logic [3:0] Minutes;
  logic       run_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        countdown;
    int          n;
    logic [15:0] exp;
    logic        exp_run;
  } vec_t;

  vec_t vecs[19];

  stopwatch #(.TICK_DIV(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (Start),
    .Stop           (Stop),
    .Countdown      (Countdown),
    .Tenths_Seconds (Tenths_Seconds),
    .Ones_Seconds   (Ones_Seconds),
    .Tens_Seconds   (Tens_Seconds),
    .Minutes        (Minutes),
    .run_state      (run_state)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: n rising edges, then park on the falling edge where inputs change and outputs are sampled.
  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: digits packed as {Minutes, Tens, Ones, Tenths}.
  task automatic check(input string name, input logic [15:0] exp, input logic exp_run);
    logic [15:0] act;
    act = {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
    checks++;
    if (act !== exp || run_state !== exp_run) begin
      errors++;
      $display("FAIL %s: got %h run=%b, expected %h run=%b", name, act, run_state, exp, exp_run);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1,   16'h0000, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 100, 16'h0100, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10,  16'h0101, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 200, 16'h0101, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1,   16'h0101, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 50,  16'h0151, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 448, 16'h0599, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1,   16'h1000, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1,   16'h1001, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1,   16'h1001, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 9,   16'h1010, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 3,   16'h1011, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1,   16'h1011, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 12,  16'h0599, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 599, 16'h0000, 1'b1};
`ifdef STOPWATCH_SATURATE_EN
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1,   16'h0000, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1,   16'h0000, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1,   16'h0001, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1,   16'h0002, 1'b1};
`else
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1,   16'h9599, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1,   16'h9598, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1,   16'h9599, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1,   16'h0000, 1'b1};
`endif

    // Power-on reset, then idle with Start/Stop low.
    reset = 1'b0; Start = 1'b0; Stop = 1'b0; Countdown = 1'b0;
    #1;
    check("por_clear", 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_edges(20);
    check("idle_after_release", 16'h0000, 1'b0);

    for (int i = 0; i < 19; i++) begin
      Start = vecs[i].start;
      Stop = vecs[i].stop;
      Countdown = vecs[i].countdown;
      run_edges(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_run);
    end

    // Reset while running clears asynchronously, between clock edges.
    Start = 1'b0; Stop = 1'b0; Countdown = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_reset_running", 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    Start = 1'b1;
    run_edges(1);
    Start = 1'b0;
    run_edges(2074);
    check("count_to_3_27_4", 16'h3274, 1'b1);
    #2 Start = 1'b1; reset = 1'b0;
    #1 check("async_reset_at_3_27_4", 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    Start = 1'b0;
    run_edges(20);
    check("held_after_reset", 16'h0000, 1'b0);

    // Up-count terminal value.
    Start = 1'b1;
    run_edges(1);
    Start = 1'b0;
    run_edges(5999);
    check("up_to_9_59_9", 16'h9599, 1'b1);
    run_edges(1);
`ifdef STOPWATCH_SATURATE_EN
    check("up_terminal", 16'h9599, 1'b1);
    run_edges(1);
    check("up_terminal_again", 16'h9599, 1'b1);
`else
    check("up_terminal", 16'h0000, 1'b1);
    run_edges(1);
    check("up_terminal_again", 16'h0001, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
